// File: rtl/ofdm_qpsk_demapper_if.sv
// Symbol stream from the QPSK demapper to the downstream bit sink.
// The master holds the payload stable while o_valid=1 and i_ready=0.
interface ofdm_qpsk_demapper_if #(
    parameter int IDX_W = 4
);
    logic             o_valid;
    logic             i_ready;
    logic [1:0]       o_sym;
    logic [IDX_W-1:0] o_bin_idx;
    logic             o_erase;
    logic             o_last;

    modport master (
        output o_valid, o_sym, o_bin_idx, o_erase, o_last,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_sym, o_bin_idx, o_erase, o_last,
        output i_ready
    );
endinterface

// File: rtl/ofdm_qpsk_demapper.sv
// Snapshots one frame of FFT bins and streams a QPSK hard decision plus a
// low-energy erasure flag for each active bin, in ascending bin order.
module ofdm_qpsk_demapper #(
    parameter int              N        = 16,
    parameter int              Q        = 8,
    parameter int              BINS     = 16,
    parameter logic [BINS-1:0] BIN_MASK = 16'hFFFF,
    parameter logic [N-1:0]    THRESH   = 16'h0020
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_fft_done,
    input  logic [BINS*N-1:0]   in_bins_re,
    input  logic [BINS*N-1:0]   in_bins_im,
    ofdm_qpsk_demapper_if.master sym_if,
    output logic                o_busy,
    output logic                o_overrun
);
    localparam int IDX_W = $clog2(BINS);

    // THRESH is a Q-format magnitude, so it must be non-negative and Q must fit in N.
    if (Q >= N || THRESH[N-1]) begin : g_bad_cfg
        $error("ofdm_qpsk_demapper: invalid Q or THRESH");
    end

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    function automatic logic signed [N-1:0] sat_abs(input logic signed [N-1:0] x);
        logic signed [N-1:0] most_neg;
        most_neg = {1'b1, {(N-1){1'b0}}};
        if (x == most_neg)
            return {1'b0, {(N-1){1'b1}}};
        else if (x[N-1])
            return -x;
        else
            return x;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [BINS*N-1:0]  r_bank_re;
    logic [BINS*N-1:0]  r_bank_im;
    logic               r_overrun;
    logic               w_overrun_nxt;
    logic               w_capture;
    logic               w_active;
    logic               w_valid;
    logic               w_advance;
    logic               w_last;
    logic               w_erase;
    logic signed [N-1:0] w_re;
    logic signed [N-1:0] w_im;
    logic signed [N-1:0] w_abs_re;
    logic signed [N-1:0] w_abs_im;

    assign w_active  = BIN_MASK[r_idx];
    assign w_valid   = (r_state == SCAN) && w_active;
    assign w_advance = !w_active || sym_if.i_ready;
    assign w_last    = ((BIN_MASK >> r_idx) >> 1) == '0;

    assign w_re     = r_bank_re[int'(r_idx)*N +: N];
    assign w_im     = r_bank_im[int'(r_idx)*N +: N];
    assign w_abs_re = sat_abs(w_re);
    assign w_abs_im = sat_abs(w_im);
    assign w_erase  = (w_abs_re < $signed(THRESH)) && (w_abs_im < $signed(THRESH));

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_capture     = 1'b0;
        w_overrun_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_fft_done) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                // A new frame arriving mid-scan is dropped, including on the exit cycle.
                w_overrun_nxt = i_fft_done;
                if (w_advance) begin
                    if (r_idx == IDX_W'(BINS-1)) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_overrun <= 1'b0;
            r_bank_re <= '0;
            r_bank_im <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_overrun <= w_overrun_nxt;
            if (w_capture) begin
                r_bank_re <= in_bins_re;
                r_bank_im <= in_bins_im;
            end
        end
    end

    // Payload is gated by o_valid so every output reads 0 outside a symbol.
    assign sym_if.o_valid   = w_valid;
    assign sym_if.o_sym     = w_valid ? {w_re[N-1], w_im[N-1]} : 2'b00;
    assign sym_if.o_bin_idx = w_valid ? r_idx : '0;
    assign sym_if.o_erase   = w_valid && w_erase;
    assign sym_if.o_last    = w_valid && w_last;
    assign o_busy           = (r_state == SCAN);
    assign o_overrun        = r_overrun;
endmodule

// File: tb/tb_ofdm_qpsk_demapper.sv
// Directed bench for ofdm_qpsk_demapper: full-mask and sparse-mask instances.
module tb_ofdm_qpsk_demapper;
    localparam int N    = 16;
    localparam int BINS = 16;

    logic clk = 1'b0;
    logic rst;
    logic done_a, done_b;
    logic [BINS*N-1:0] bins_re, bins_im;
    logic busy_a, ovr_a, busy_b, ovr_b;

    int errors = 0;
    int checks = 0;
    int f1_sym [16];
    int f1_ers [16];
    int b_list [4] = '{1, 2, 4, 8};

    always #5 clk = ~clk;

    ofdm_qpsk_demapper_if if_a ();
    ofdm_qpsk_demapper_if if_b ();

    ofdm_qpsk_demapper dut_a (
        .i_clk(clk), .i_rst(rst), .i_fft_done(done_a),
        .in_bins_re(bins_re), .in_bins_im(bins_im),
        .sym_if(if_a.master), .o_busy(busy_a), .o_overrun(ovr_a)
    );

    ofdm_qpsk_demapper #(.BIN_MASK(16'h0116)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_fft_done(done_b),
        .in_bins_re(bins_re), .in_bins_im(bins_im),
        .sym_if(if_b.master), .o_busy(busy_b), .o_overrun(ovr_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_bin(input string tag, input int k, input logic v, input logic [3:0] idx,
                             input logic [1:0] sym, input logic ers, input logic last,
                             input int es, input int ee, input int el);
        check({tag, "_valid"}, 32'(v), 1);
        check({tag, "_idx"}, 32'(idx), k);
        check({tag, "_sym"}, 32'(sym), es);
        check({tag, "_erase"}, 32'(ers), ee);
        check({tag, "_last"}, 32'(last), el);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bin(input int k, input logic [15:0] re, input logic [15:0] im);
        bins_re[k*N +: N] = re;
        bins_im[k*N +: N] = im;
    endtask

    task automatic set_frame1();
        bins_re = '0;
        bins_im = '0;
        set_bin(1, 16'h016A, 16'h00C9);
        set_bin(2, 16'hFE96, 16'h00C9);
        set_bin(4, 16'h016A, 16'hFF37);
        set_bin(8, 16'hFE96, 16'hFF37);
    endtask

    task automatic drain_a(input string tag);
        int n;
        n = 0;
        if_a.i_ready = 1'b1;
        while (busy_a && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(busy_a), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_k, cyc, n, hs_cyc;

        for (int k = 0; k < 16; k++) begin
            f1_sym[k] = 0;
            f1_ers[k] = 1;
        end
        f1_ers[1] = 0; f1_ers[2] = 0; f1_ers[4] = 0; f1_ers[8] = 0;
        f1_sym[2] = 2; f1_sym[4] = 1; f1_sym[8] = 3;

        rst = 1'b1;
        done_a = 1'b0;
        done_b = 1'b0;
        if_a.i_ready = 1'b0;
        if_b.i_ready = 1'b0;
        bins_re = '0;
        bins_im = '0;
        repeat (2) tick();
        check("rst_valid", 32'(if_a.o_valid), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_overrun", 32'(ovr_a), 0);
        check("rst_sym", 32'(if_a.o_sym), 0);
        rst = 1'b0;

        // Full frame with i_ready held high: one symbol per cycle.
        set_frame1();
        if_a.i_ready = 1'b1;
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check_bin("frame", k, if_a.o_valid, if_a.o_bin_idx, if_a.o_sym, if_a.o_erase,
                      if_a.o_last, f1_sym[k], f1_ers[k], (k == 15) ? 1 : 0);
            check("frame_busy", 32'(busy_a), 1);
            tick();
        end
        check("frame_end_busy", 32'(busy_a), 0);
        check("frame_end_valid", 32'(if_a.o_valid), 0);

        // Backpressure with ready pattern 1-0-0-1.
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        exp_k = 0;
        cyc = 0;
        while (exp_k < 16 && cyc < 200) begin
            if_a.i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            check_bin("bp", exp_k, if_a.o_valid, if_a.o_bin_idx, if_a.o_sym, if_a.o_erase,
                      if_a.o_last, f1_sym[exp_k], f1_ers[exp_k], (exp_k == 15) ? 1 : 0);
            if (if_a.i_ready) exp_k++;
            cyc++;
            tick();
        end
        check("bp_count", exp_k, 16);
        check("bp_end_busy", 32'(busy_a), 0);

        // Overrun: second frame arrives while stalled on bin 3.
        if_a.i_ready = 1'b0;
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        if_a.i_ready = 1'b1;
        repeat (3) tick();
        if_a.i_ready = 1'b0;
        check("ovr_idx", 32'(if_a.o_bin_idx), 3);
        for (int k = 0; k < 16; k++) set_bin(k, 16'hFE00, 16'hFE00);
        done_a = 1'b1;
        check("ovr_pre", 32'(ovr_a), 0);
        tick();
        done_a = 1'b0;
        check("ovr_pulse", 32'(ovr_a), 1);
        tick();
        check("ovr_clear", 32'(ovr_a), 0);
        if_a.i_ready = 1'b1;
        for (int k = 3; k < 16; k++) begin
            check_bin("ovr", k, if_a.o_valid, if_a.o_bin_idx, if_a.o_sym, if_a.o_erase,
                      if_a.o_last, f1_sym[k], f1_ers[k], (k == 15) ? 1 : 0);
            check("ovr_quiet", 32'(ovr_a), 0);
            tick();
        end
        check("ovr_end_busy", 32'(busy_a), 0);

        // Asynchronous reset while stalled on bin 5.
        set_frame1();
        set_bin(5, 16'hFE96, 16'hFF37);
        if_a.i_ready = 1'b1;
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        repeat (5) tick();
        if_a.i_ready = 1'b0;
        check_bin("mid", 5, if_a.o_valid, if_a.o_bin_idx, if_a.o_sym, if_a.o_erase,
                  if_a.o_last, 3, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(if_a.o_valid), 0);
        check("mid_rst_busy", 32'(busy_a), 0);
        check("mid_rst_sym", 32'(if_a.o_sym), 0);
        check("mid_rst_idx", 32'(if_a.o_bin_idx), 0);
        tick();
        rst = 1'b0;
        set_frame1();
        if_a.i_ready = 1'b1;
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        check_bin("restart", 0, if_a.o_valid, if_a.o_bin_idx, if_a.o_sym, if_a.o_erase,
                  if_a.o_last, 0, 1, 0);
        drain_a("restart_drain");

        // Edge values: saturated |0x8000| and threshold boundary.
        bins_re = '0;
        bins_im = '0;
        set_bin(0, 16'h8000, 16'h0000);
        set_bin(1, 16'h001F, 16'hFFE1);
        set_bin(2, 16'h0020, 16'h0000);
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        check_bin("edge0", 0, if_a.o_valid, if_a.o_bin_idx, if_a.o_sym, if_a.o_erase,
                  if_a.o_last, 2, 0, 0);
        tick();
        check_bin("edge1", 1, if_a.o_valid, if_a.o_bin_idx, if_a.o_sym, if_a.o_erase,
                  if_a.o_last, 1, 1, 0);
        tick();
        check_bin("edge2", 2, if_a.o_valid, if_a.o_bin_idx, if_a.o_sym, if_a.o_erase,
                  if_a.o_last, 0, 0, 0);
        drain_a("edge_drain");

        // Sparse mask 0x0116 on the second instance.
        set_frame1();
        if_b.i_ready = 1'b1;
        done_b = 1'b1;
        tick();
        done_b = 1'b0;
        n = 0;
        hs_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            if (if_b.o_valid) begin
                if (n < 4) begin
                    check_bin("mask", b_list[n], if_b.o_valid, if_b.o_bin_idx, if_b.o_sym,
                              if_b.o_erase, if_b.o_last, f1_sym[b_list[n]], f1_ers[b_list[n]],
                              (n == 3) ? 1 : 0);
                    if (n == 3) hs_cyc = c;
                end else begin
                    check("mask_extra", 32'(if_b.o_bin_idx), 32'hFFFF);
                end
                n++;
            end
            if (hs_cyc >= 0 && c == hs_cyc + 7) check("mask_busy_hold", 32'(busy_b), 1);
            if (hs_cyc >= 0 && c == hs_cyc + 8) check("mask_busy_clear", 32'(busy_b), 0);
            tick();
        end
        check("mask_count", n, 4);
        check("mask_seen_last", (hs_cyc >= 0) ? 1 : 0, 1);
        check("mask_overrun", 32'(ovr_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
